tlb_op_sequencer: RTL and testbench

- Sequences the privileged TLB instructions TLBP, TLBR, TLBWI and TLBWR from the M stage into the shared TLB array.
- Generates one-cycle command strobes to the TLB.
- Registers TLB results and writes them back to the CP0 Index/EntryHi/PageMask/EntryLo0/EntryLo1 registers.
- Owns the CP0 Random register (bounded by Wired) and requests a pipeline refetch after any TLB write, so that instructions already fetched under stale translations are discarded.

---
 rtl/tlb_op_sequencer_pkg.sv | 24 ++
 rtl/tlb_op_sequencer_random_ctr.sv | 38 +++
 rtl/tlb_op_sequencer.sv | 162 ++++++++++++++++
 tb/tb_tlb_op_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_op_sequencer_pkg.sv
// Shared encodings and sizing for the TLB instruction sequencer and its Random counter.
package tlb_op_sequencer_pkg;

    localparam int TLB_LINE_NUM      = 32;
    localparam int LOG2_TLB_LINE_NUM = 5;

    // Index value the TLB returns when a probe finds no matching entry.
    localparam logic [31:0] TLBP_MISS = 32'h8000_0000;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'b00,
        OP_TLBR  = 2'b01,
        OP_TLBWI = 2'b10,
        OP_TLBWR = 2'b11
    } tlb_op_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ISSUE   = 2'b01,
        S_CAPTURE = 2'b10,
        S_REFETCH = 2'b11
    } seq_state_e;

endpackage

// File: rtl/tlb_op_sequencer_random_ctr.sv
// CP0 Random/Wired pair: Random counts down from TLB_LINE_NUM-1 to Wired and wraps,
// with a freeze input that holds the value stable while a TLBWR is being issued.
module tlb_random_ctr
    import tlb_op_sequencer_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_freeze,
    input  logic                         i_wired_we,
    input  logic [LOG2_TLB_LINE_NUM-1:0] i_wired_wdata,
    output logic [LOG2_TLB_LINE_NUM-1:0] o_random
);

    localparam logic [LOG2_TLB_LINE_NUM-1:0] RAND_TOP = LOG2_TLB_LINE_NUM'(TLB_LINE_NUM - 1);

    logic [LOG2_TLB_LINE_NUM-1:0] r_random;
    logic [LOG2_TLB_LINE_NUM-1:0] r_wired;

    // A Wired write restarts Random at the top even while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_random <= RAND_TOP;
            r_wired  <= '0;
        end else if (i_wired_we) begin
            r_wired  <= i_wired_wdata;
            r_random <= RAND_TOP;
        end else if (!i_freeze) begin
            if (r_wired >= RAND_TOP || r_random == r_wired) begin
                r_random <= RAND_TOP;
            end else begin
                r_random <= r_random - 1'b1;
            end
        end
    end

    assign o_random = r_random;

endmodule

// File: rtl/tlb_op_sequencer.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR from the M stage: issue strobe, then either a CP0
// write-back of the TLB result or a refetch request after a TLB write.
module tlb_op_sequencer
    import tlb_op_sequencer_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         op_valid,
    input  logic [1:0]                   op_code,
    input  logic [31:0]                  op_pc,
    input  logic                         flush_in,
    output logic                         op_ready,
    output logic                         stall,
    output logic                         tlbp_o,
    output logic                         tlbr_o,
    output logic                         tlbwi_o,
    output logic                         tlbwr_o,
    output logic [31:0]                  random_o,
    input  logic [31:0]                  tlb_index_in,
    input  logic [31:0]                  tlb_entryhi_in,
    input  logic [31:0]                  tlb_pagemask_in,
    input  logic [31:0]                  tlb_lo0_in,
    input  logic [31:0]                  tlb_lo1_in,
    output logic                         cp0_index_we,
    output logic [31:0]                  cp0_index_wdata,
    output logic                         cp0_tlbr_we,
    output logic [31:0]                  cp0_entryhi_wdata,
    output logic [31:0]                  cp0_pagemask_wdata,
    output logic [31:0]                  cp0_lo0_wdata,
    output logic [31:0]                  cp0_lo1_wdata,
    input  logic                         wired_we,
    input  logic [LOG2_TLB_LINE_NUM-1:0] wired_wdata,
    output logic                         refetch_req,
    output logic [31:0]                  refetch_pc,
    output seq_state_e                   dbg_state
);

    seq_state_e  r_state;
    tlb_op_e     r_op;
    logic [31:0] r_pc;
    logic        r_tlbp;
    logic        r_tlbr;
    logic        r_tlbwi;
    logic        r_tlbwr;
    logic        r_index_we;
    logic        r_tlbr_we;
    logic        r_refetch;
    logic [31:0] r_index;
    logic [31:0] r_entryhi;
    logic [31:0] r_pagemask;
    logic [31:0] r_lo0;
    logic [31:0] r_lo1;
    logic [31:0] r_refetch_pc;

    logic                         w_idle;
    logic                         w_accept;
    logic                         w_freeze;
    logic [LOG2_TLB_LINE_NUM-1:0] w_random;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle & op_valid & ~flush_in;
    assign w_freeze = (r_state == S_ISSUE) & (r_op == OP_TLBWR);

    tlb_random_ctr u_random_ctr (
        .clk          (clk),
        .rst          (rst),
        .i_freeze     (w_freeze),
        .i_wired_we   (wired_we),
        .i_wired_wdata(wired_wdata),
        .o_random     (w_random)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= OP_TLBP;
            r_pc         <= '0;
            r_tlbp       <= 1'b0;
            r_tlbr       <= 1'b0;
            r_tlbwi      <= 1'b0;
            r_tlbwr      <= 1'b0;
            r_index_we   <= 1'b0;
            r_tlbr_we    <= 1'b0;
            r_refetch    <= 1'b0;
            r_index      <= '0;
            r_entryhi    <= '0;
            r_pagemask   <= '0;
            r_lo0        <= '0;
            r_lo1        <= '0;
            r_refetch_pc <= '0;
        end else begin
            r_tlbp     <= 1'b0;
            r_tlbr     <= 1'b0;
            r_tlbwi    <= 1'b0;
            r_tlbwr    <= 1'b0;
            r_index_we <= 1'b0;
            r_tlbr_we  <= 1'b0;
            r_refetch  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= tlb_op_e'(op_code);
                        r_pc    <= op_pc;
                        r_tlbp  <= (op_code == OP_TLBP);
                        r_tlbr  <= (op_code == OP_TLBR);
                        r_tlbwi <= (op_code == OP_TLBWI);
                        r_tlbwr <= (op_code == OP_TLBWR);
                        r_state <= S_ISSUE;
                    end
                end
                // The TLB answers combinationally while the strobe is high.
                S_ISSUE: begin
                    case (r_op)
                        OP_TLBP: begin
                            r_index    <= tlb_index_in;
                            r_index_we <= 1'b1;
                            r_state    <= S_CAPTURE;
                        end
                        OP_TLBR: begin
                            r_entryhi  <= tlb_entryhi_in;
                            r_pagemask <= tlb_pagemask_in;
                            r_lo0      <= tlb_lo0_in;
                            r_lo1      <= tlb_lo1_in;
                            r_tlbr_we  <= 1'b1;
                            r_state    <= S_CAPTURE;
                        end
                        default: begin
                            r_refetch    <= 1'b1;
                            r_refetch_pc <= r_pc + 32'd4;
                            r_state      <= S_REFETCH;
                        end
                    endcase
                end
                S_CAPTURE: r_state <= S_IDLE;
                S_REFETCH: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Pulses are masked by rst so nothing reaches the TLB or CP0 once reset is seen.
    assign tlbp_o       = r_tlbp & ~rst;
    assign tlbr_o       = r_tlbr & ~rst;
    assign tlbwi_o      = r_tlbwi & ~rst;
    assign tlbwr_o      = r_tlbwr & ~rst;
    assign cp0_index_we = r_index_we & ~rst;
    assign cp0_tlbr_we  = r_tlbr_we & ~rst;
    assign refetch_req  = r_refetch & ~rst;

    assign cp0_index_wdata    = r_index;
    assign cp0_entryhi_wdata  = r_entryhi;
    assign cp0_pagemask_wdata = r_pagemask;
    assign cp0_lo0_wdata      = r_lo0;
    assign cp0_lo1_wdata      = r_lo1;
    assign refetch_pc         = r_refetch_pc;

    assign op_ready  = w_idle & ~flush_in & ~rst;
    assign stall     = (op_valid & ~op_ready) | ~w_idle;
    assign random_o  = 32'(w_random);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Directed bench for tlb_op_sequencer with a cycle-level reference model and literal spot checks.
module tb_tlb_op_sequencer;
    import tlb_op_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [1:0]  op_code = 2'b00;
    logic [31:0] op_pc = 32'h0;
    logic        flush_in = 1'b0;
    logic        wired_we = 1'b0;
    logic [4:0]  wired_wdata = 5'd0;

    logic        op_ready, stall, tlbp_o, tlbr_o, tlbwi_o, tlbwr_o;
    logic [31:0] random_o;
    logic [31:0] tlb_index_in, tlb_entryhi_in, tlb_pagemask_in, tlb_lo0_in, tlb_lo1_in;
    logic        cp0_index_we, cp0_tlbr_we, refetch_req;
    logic [31:0] cp0_index_wdata, cp0_entryhi_wdata, cp0_pagemask_wdata, cp0_lo0_wdata, cp0_lo1_wdata;
    logic [31:0] refetch_pc;
    seq_state_e  dbg_state;

    // Stand-in TLB: answers are only valid while the matching strobe is high.
    logic [31:0] probe_result = 32'h0;
    logic [31:0] rd_hi = 32'h0, rd_pm = 32'h0, rd_lo0 = 32'h0, rd_lo1 = 32'h0;
    assign tlb_index_in    = tlbp_o ? probe_result : 32'hDEAD_BEEF;
    assign tlb_entryhi_in  = tlbr_o ? rd_hi  : 32'hDEAD_BEEF;
    assign tlb_pagemask_in = tlbr_o ? rd_pm  : 32'hDEAD_BEEF;
    assign tlb_lo0_in      = tlbr_o ? rd_lo0 : 32'hDEAD_BEEF;
    assign tlb_lo1_in      = tlbr_o ? rd_lo1 : 32'hDEAD_BEEF;

    tlb_op_sequencer dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .op_pc(op_pc),
        .flush_in(flush_in), .op_ready(op_ready), .stall(stall),
        .tlbp_o(tlbp_o), .tlbr_o(tlbr_o), .tlbwi_o(tlbwi_o), .tlbwr_o(tlbwr_o),
        .random_o(random_o), .tlb_index_in(tlb_index_in), .tlb_entryhi_in(tlb_entryhi_in),
        .tlb_pagemask_in(tlb_pagemask_in), .tlb_lo0_in(tlb_lo0_in), .tlb_lo1_in(tlb_lo1_in),
        .cp0_index_we(cp0_index_we), .cp0_index_wdata(cp0_index_wdata),
        .cp0_tlbr_we(cp0_tlbr_we), .cp0_entryhi_wdata(cp0_entryhi_wdata),
        .cp0_pagemask_wdata(cp0_pagemask_wdata), .cp0_lo0_wdata(cp0_lo0_wdata),
        .cp0_lo1_wdata(cp0_lo1_wdata), .wired_we(wired_we), .wired_wdata(wired_wdata),
        .refetch_req(refetch_req), .refetch_pc(refetch_pc), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: an accepted op at cycle t strobes at t+1, writes back at t+2,
    // and the sequencer is free again at t+3.
    int          cyc = 0;
    bit          chk_en = 1'b0;
    bit          m_active = 1'b0;
    int          m_t = 0;
    int          m_op = 0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_idx = 32'h0, m_hi = 32'h0, m_pm = 32'h0, m_lo0 = 32'h0, m_lo1 = 32'h0;
    int          m_rand = 31;
    int          m_wired = 0;

    always @(negedge clk) begin
        bit idle, s_now, w_now, rdy, freeze;
        idle  = !(m_active && cyc <= m_t + 2);
        s_now = m_active && cyc == m_t + 1 && !rst;
        w_now = m_active && cyc == m_t + 2 && !rst;
        rdy   = !rst && idle && !flush_in;
        if (chk_en) begin
            chk("m_tlbp",   32'(tlbp_o),  32'(s_now && m_op == 0));
            chk("m_tlbr",   32'(tlbr_o),  32'(s_now && m_op == 1));
            chk("m_tlbwi",  32'(tlbwi_o), 32'(s_now && m_op == 2));
            chk("m_tlbwr",  32'(tlbwr_o), 32'(s_now && m_op == 3));
            chk("m_index_we", 32'(cp0_index_we), 32'(w_now && m_op == 0));
            chk("m_tlbr_we",  32'(cp0_tlbr_we),  32'(w_now && m_op == 1));
            chk("m_refetch",  32'(refetch_req),  32'(w_now && m_op >= 2));
            if (w_now && m_op == 0) chk("m_index_wdata", cp0_index_wdata, m_idx);
            if (w_now && m_op == 1) begin
                chk("m_entryhi",  cp0_entryhi_wdata,  m_hi);
                chk("m_pagemask", cp0_pagemask_wdata, m_pm);
                chk("m_lo0",      cp0_lo0_wdata,      m_lo0);
                chk("m_lo1",      cp0_lo1_wdata,      m_lo1);
            end
            if (w_now && m_op >= 2) chk("m_refetch_pc", refetch_pc, m_pc + 32'd4);
            chk("m_random",   random_o,      32'(m_rand));
            chk("m_op_ready", 32'(op_ready), 32'(rdy));
            chk("m_stall",    32'(stall),    32'((op_valid && !rdy) || !idle));
        end
        if (rst) begin
            m_active = 1'b0;
            m_rand   = TLB_LINE_NUM - 1;
            m_wired  = 0;
        end else begin
            freeze = m_active && cyc == m_t + 1 && m_op == 3;
            if (m_active && cyc == m_t + 1) begin
                m_idx = tlb_index_in;
                m_hi  = tlb_entryhi_in;
                m_pm  = tlb_pagemask_in;
                m_lo0 = tlb_lo0_in;
                m_lo1 = tlb_lo1_in;
            end
            if (wired_we) begin
                m_wired = int'(wired_wdata);
                m_rand  = TLB_LINE_NUM - 1;
            end else if (!freeze) begin
                if (m_wired >= TLB_LINE_NUM - 1 || m_rand == m_wired) m_rand = TLB_LINE_NUM - 1;
                else m_rand = m_rand - 1;
            end
            if (idle && op_valid && !flush_in) begin
                m_active = 1'b1;
                m_t      = cyc;
                m_op     = int'(op_code);
                m_pc     = op_pc;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents an op and returns just after the edge that accepted it.
    task automatic do_op(input logic [1:0] op, input logic [31:0] pc);
        op_code  = op;
        op_pc    = pc;
        op_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (op_ready) begin
                step();
                op_valid = 1'b0;
                return;
            end
            step();
        end
        op_valid = 1'b0;
        n_total++;
        n_bad++;
        $display("FAIL do_op_accept: got no acceptance within 50 cycles want acceptance");
    endtask

    initial begin
        bit found;
        repeat (3) step();
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset values, then free-running countdown 31..0 and wrap to 31.
        @(negedge clk);
        chk("rst_tlbp",     32'(tlbp_o), 32'd0);
        chk("rst_tlbwr",    32'(tlbwr_o), 32'd0);
        chk("rst_index_we", 32'(cp0_index_we), 32'd0);
        chk("rst_refetch",  32'(refetch_req), 32'd0);
        chk("rst_random",   random_o, 32'd31);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            chk("countdown", random_o, (k <= 31) ? 32'(31 - k) : 32'd31);
        end

        // TLBP hit on entry 5, then a miss.
        step();
        probe_result = 32'h0000_0005;
        do_op(OP_TLBP, 32'h8000_0100);
        @(negedge clk) chk("tlbp_strobe", 32'(tlbp_o), 32'd1);
        @(negedge clk);
        chk("tlbp_hit_we",    32'(cp0_index_we), 32'd1);
        chk("tlbp_hit_index", cp0_index_wdata, 32'h0000_0005);
        step();
        probe_result = TLBP_MISS;
        do_op(OP_TLBP, 32'h8000_0200);
        @(negedge clk);
        @(negedge clk);
        chk("tlbp_miss_index", cp0_index_wdata, 32'h8000_0000);

        // TLBR of entry 3 with the G bit set in both halves.
        step();
        rd_hi  = 32'h0040_2001;
        rd_pm  = 32'h0000_0000;
        rd_lo0 = 32'h0000_1017;
        rd_lo1 = 32'h0000_1057;
        do_op(OP_TLBR, 32'h8000_0300);
        @(negedge clk) chk("tlbr_strobe", 32'(tlbr_o), 32'd1);
        @(negedge clk);
        chk("tlbr_we",      32'(cp0_tlbr_we), 32'd1);
        chk("tlbr_entryhi", cp0_entryhi_wdata, 32'h0040_2001);
        chk("tlbr_lo0",     cp0_lo0_wdata, 32'h0000_1017);
        chk("tlbr_lo1",     cp0_lo1_wdata, 32'h0000_1057);

        // Back-to-back TLBWI with op_valid held: acceptance every third cycle.
        step();
        op_code  = OP_TLBWI;
        op_pc    = 32'h0000_1000;
        op_valid = 1'b1;
        repeat (6) step();
        op_valid = 1'b0;
        repeat (3) step();

        // TLBWR with Wired=8, issued so the strobe sees Random=20.
        wired_we    = 1'b1;
        wired_wdata = 5'd8;
        step();
        wired_we = 1'b0;
        @(negedge clk) chk("wired_restart", random_o, 32'd31);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (random_o == 32'd21) found = 1'b1;
        end
        if (!found) begin
            n_total++;
            n_bad++;
            $display("FAIL random_reach_21: got %h want 00000015", random_o);
        end
        do_op(OP_TLBWR, 32'hBFC0_1000);
        @(negedge clk);
        chk("tlbwr_strobe", 32'(tlbwr_o), 32'd1);
        chk("tlbwr_random", random_o, 32'd20);
        @(negedge clk);
        chk("tlbwr_refetch",    32'(refetch_req), 32'd1);
        chk("tlbwr_refetch_pc", refetch_pc, 32'hBFC0_1004);
        for (int i = 0; i < 40; i++) begin
            step();
            chk("random_floor", 32'(random_o >= 32'd8), 32'd1);
        end

        // Wired at the top: Random pinned at 31.
        wired_we    = 1'b1;
        wired_wdata = 5'd31;
        step();
        wired_we = 1'b0;
        repeat (4) begin
            step();
            chk("wired_top_hold", random_o, 32'd31);
        end
        wired_we    = 1'b1;
        wired_wdata = 5'd0;
        step();
        wired_we = 1'b0;

        // flush_in in IDLE blocks acceptance.
        flush_in = 1'b1;
        op_valid = 1'b1;
        op_code  = OP_TLBWI;
        op_pc    = 32'h0000_4000;
        repeat (3) begin
            @(negedge clk);
            chk("flush_ready", 32'(op_ready), 32'd0);
            chk("flush_stall", 32'(stall), 32'd1);
            chk("flush_no_strobe", 32'(tlbwi_o), 32'd0);
            step();
        end
        flush_in = 1'b0;
        op_valid = 1'b0;

        // flush_in after acceptance does not cancel TLBWI.
        step();
        do_op(OP_TLBWI, 32'h0000_2000);
        flush_in = 1'b1;
        @(negedge clk) chk("flush_issue_strobe", 32'(tlbwi_o), 32'd1);
        @(negedge clk);
        chk("flush_issue_refetch",    32'(refetch_req), 32'd1);
        chk("flush_issue_refetch_pc", refetch_pc, 32'h0000_2004);
        step();
        flush_in = 1'b0;

        // Reset during ISSUE of TLBWI.
        step();
        do_op(OP_TLBWI, 32'h0000_3000);
        rst = 1'b1;
        @(negedge clk) chk("rst_issue_strobe", 32'(tlbwi_o), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_issue_random", random_o, 32'd31);
        chk("rst_issue_state",  32'(dbg_state), 32'(S_IDLE));
        chk("rst_issue_refetch", 32'(refetch_req), 32'd0);
        repeat (4) begin
            step();
            chk("rst_issue_no_refetch", 32'(refetch_req), 32'd0);
        end

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
